// File: rtl/garduino_sys_v1_sys_cpu_v1_debug_ocimem_master.sv
// ---------------------------------------------------------------------------
// garduino_sys_v1_sys_cpu_v1_debug_ocimem_master
//
// Consumes the sysclk-side OCI memory commands from the Nios II JTAG debug
// module and turns each one into a single-word Avalon-MM read or write.
// The bus address auto-increments after writes and after read-next commands.
// A request that stalls too long is aborted and reported through
// monitor_error. The result of each command is returned in MonDReg,
// monitor_ready and monitor_error.
//
// Ports:
//   clk, reset_n              system clock, async active-low reset
//   jdo[37:0]                 debug data word ([35] = read-after-load,
//                             [31:0] = address or write data)
//   take_action_ocimem_a      pulse: load address (optionally read)
//   take_no_action_ocimem_a   pulse: read next word
//   take_action_ocimem_b      pulse: write word
//   avm_*                     Avalon-MM master, one word per command
//   MonDReg                   monitor data register (read result / wdata)
//   monitor_ready             engine idle, last command finished
//   monitor_error             last command aborted by timeout
// ---------------------------------------------------------------------------
module garduino_sys_v1_sys_cpu_v1_debug_ocimem_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  // Abort fires on the stall cycle that brings the count up to TIMEOUT_CYCLES.
  localparam logic [15:0]       TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mon_areg_q, mon_areg_d;
  logic [31:0]       mon_dreg_q, mon_dreg_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              inc_q, inc_d;     // read-next: bump address on completion
  logic [15:0]       cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  // jdo bits that carry no meaning for this engine.
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:36], jdo[34:32]};

  // Next-state logic: command decode in IDLE, completion/timeout when busy.
  always_comb begin
    state_d    = state_q;
    mon_areg_d = mon_areg_q;
    mon_dreg_d = mon_dreg_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    inc_d      = inc_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          mon_areg_d = {jdo[ADDR_W-1:2], 2'b00};
          if (jdo[35]) begin
            state_d = ST_RD;
            rd_d    = 1'b1;
            inc_d   = 1'b0;
            cnt_d   = 16'd0;
            ready_d = 1'b0;
            err_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (take_action_ocimem_b) begin
          mon_dreg_d = jdo[31:0];
          state_d    = ST_WR;
          wr_d       = 1'b1;
          cnt_d      = 16'd0;
          ready_d    = 1'b0;
          err_d      = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          state_d = ST_RD;
          rd_d    = 1'b1;
          inc_d   = 1'b1;
          cnt_d   = 16'd0;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD, ST_WR: begin
        if (!avm_waitrequest) begin
          if (state_q == ST_RD) begin
            mon_dreg_d = avm_readdata;
            if (inc_q) begin
              mon_areg_d = mon_areg_q + ADDR_STEP;
            end else begin
              mon_areg_d = mon_areg_q;
            end
          end else begin
            mon_areg_d = mon_areg_q + ADDR_STEP;
          end
          state_d = ST_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ready_d = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          // Stuck slave: abandon the request, leave MonAReg/MonDReg alone.
          state_d = ST_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any bus request at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mon_areg_q <= '0;
      mon_dreg_q <= 32'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      inc_q      <= 1'b0;
      cnt_q      <= 16'd0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mon_areg_q <= mon_areg_d;
      mon_dreg_q <= mon_dreg_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      inc_q      <= inc_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign avm_address    = mon_areg_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = mon_dreg_q;
  assign avm_byteenable = 4'hF;
  assign MonDReg        = mon_dreg_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = err_q;

endmodule

// File: tb/tb_garduino_sys_v1_sys_cpu_v1_debug_ocimem_master.sv
// ---------------------------------------------------------------------------
// Bench for garduino_sys_v1_sys_cpu_v1_debug_ocimem_master.
// Each debugger command is treated as one transaction: the reference model
// holds MonAReg/MonDReg/ready/error and decides, from the command type and
// the number of stall cycles the bench applies, how many bus cycles the
// request must last and what the registers must hold afterwards.
// ---------------------------------------------------------------------------
module tb_garduino_sys_v1_sys_cpu_v1_debug_ocimem_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_areg;
  logic [31:0] m_dreg;
  logic        m_ready;
  logic        m_err;

  always #5 clk = ~clk;

  garduino_sys_v1_sys_cpu_v1_debug_ocimem_master #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_write              (avm_write),
    .avm_writedata          (avm_writedata),
    .avm_byteenable         (avm_byteenable),
    .avm_readdata           (avm_readdata),
    .avm_waitrequest        (avm_waitrequest),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_rd"},    64'(avm_read), 64'd0);
    check_eq({tag, "_wr"},    64'(avm_write), 64'd0);
    check_eq({tag, "_addr"},  64'(avm_address), 64'(m_areg));
    check_eq({tag, "_dreg"},  64'(MonDReg), 64'(m_dreg));
    check_eq({tag, "_wdata"}, 64'(avm_writedata), 64'(m_dreg));
    check_eq({tag, "_be"},    64'(avm_byteenable), 64'hF);
    check_eq({tag, "_rdy"},   64'(monitor_ready), 64'(m_ready));
    check_eq({tag, "_err"},   64'(monitor_error), 64'(m_err));
  endtask

  task automatic clear_pulses();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  // One command: pulses pa/pb/pn together, slave stalls 'stalls' cycles,
  // optional stray pulses while busy (must be ignored).
  task automatic run_cmd(input logic pa, input logic pb, input logic pn,
                         input logic [37:0] j, input int stalls,
                         input logic [31:0] rd, input logic stray);
    int kind; // 0 none, 1 load only, 2 load+read, 3 write, 4 read-next
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a    = pa;
    take_action_ocimem_b    = pb;
    take_no_action_ocimem_a = pn;
    @(posedge clk);
    @(negedge clk);
    clear_pulses();
    jdo = 38'($urandom());
    if (pa) begin
      m_areg = {j[31:2], 2'b00};
      kind = j[35] ? 2 : 1;
    end else if (pb) begin
      m_dreg = j[31:0];
      kind = 3;
    end else if (pn) begin
      kind = 4;
    end else begin
      kind = 0;
    end
    if (kind <= 1) begin
      check_idle("nobus");
      return;
    end
    m_ready = 1'b0;
    m_err   = 1'b0;
    for (int c = 0; c <= TO; c++) begin
      check_eq("busy_rd",   64'(avm_read), 64'(kind != 3));
      check_eq("busy_wr",   64'(avm_write), 64'(kind == 3));
      check_eq("busy_addr", 64'(avm_address), 64'(m_areg));
      check_eq("busy_dreg", 64'(MonDReg), 64'(m_dreg));
      check_eq("busy_rdy",  64'(monitor_ready), 64'd0);
      check_eq("busy_err",  64'(monitor_error), 64'd0);
      avm_waitrequest = (c < stalls);
      avm_readdata    = rd;
      if (stray) begin
        jdo = {2'b00, 1'b1, 3'b000, $urandom()};
        case ($urandom_range(0, 2))
          0:       take_action_ocimem_a    = 1'b1;
          1:       take_action_ocimem_b    = 1'b1;
          default: take_no_action_ocimem_a = 1'b1;
        endcase
      end
      @(posedge clk);
      @(negedge clk);
      clear_pulses();
      avm_waitrequest = 1'b0;
      avm_readdata    = $urandom();
      if (c == stalls) begin
        if (kind == 3) begin
          m_areg = m_areg + 32'd4;
        end else begin
          m_dreg = rd;
          if (kind == 4) m_areg = m_areg + 32'd4;
        end
        break;
      end
      if (c == TO - 1) begin
        m_err = 1'b1;
        break;
      end
    end
    m_ready = 1'b1;
    check_idle("done");
  endtask

  initial begin
    logic [2:0] p;
    reset_n         = 1'b0;
    jdo             = 38'd0;
    clear_pulses();
    avm_readdata    = 32'd0;
    avm_waitrequest = 1'b0;
    m_areg  = 32'd0;
    m_dreg  = 32'd0;
    m_ready = 1'b1;
    m_err   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;

    // Address load with read, no stall: MonAReg must not increment.
    run_cmd(1'b1, 1'b0, 1'b0, {2'b00, 1'b1, 3'b000, 32'h0000_1003}, 0, 32'hCAFE_F00D, 1'b0);
    // Write with 3 stall cycles.
    run_cmd(1'b0, 1'b1, 1'b0, {6'd0, 32'h1234_5678}, 3, 32'd0, 1'b0);
    // Load top word without read, then read-next wraps to 0.
    run_cmd(1'b1, 1'b0, 1'b0, {2'b00, 1'b0, 3'b000, 32'hFFFF_FFFF}, 0, 32'd0, 1'b0);
    run_cmd(1'b0, 1'b0, 1'b1, 38'd0, 0, 32'h5A5A_0001, 1'b0);
    check_eq("wrap_addr", 64'(avm_address), 64'd0);
    // Stuck write times out, then a clean read-next clears the error.
    run_cmd(1'b0, 1'b1, 1'b0, {6'd0, 32'hDEAD_BEEF}, 20, 32'd0, 1'b0);
    check_eq("to_err", 64'(monitor_error), 64'd1);
    run_cmd(1'b0, 1'b0, 1'b1, 38'd0, 0, 32'h0BAD_CAFE, 1'b0);
    // Load and write in the same cycle: only the load runs; stray pulses while busy.
    run_cmd(1'b1, 1'b1, 1'b0, {2'b00, 1'b1, 3'b000, 32'h0000_2000}, 2, 32'h7777_8888, 1'b1);

    // Reset asserted while a read is stalled.
    @(negedge clk);
    take_no_action_ocimem_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_pulses();
    avm_waitrequest = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_pre_rd", 64'(avm_read), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    m_areg  = 32'd0;
    m_dreg  = 32'd0;
    m_ready = 1'b1;
    m_err   = 1'b0;
    check_idle("rst_async");
    @(negedge clk);
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check_idle("rst_after");

    // Randomized commands.
    for (int i = 0; i < 80; i++) begin
      p = 3'($urandom_range(1, 7));
      run_cmd(p[0], p[1], p[2], {6'($urandom()), 32'($urandom())},
              $urandom_range(0, 6), $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/garduino_sys_v1_sys_cpu_v1_debug_ocimem_master.md
Name: garduino_sys_v1_sys_cpu_v1_debug_ocimem_master

Overview:
Downstream consumer of the Nios II JTAG debug module's sysclk-domain outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a). It turns debugger OCI memory commands into single-word Avalon-MM master reads and writes on the system bus, with address auto-increment and a bus timeout. It returns MonDReg, monitor_ready and monitor_error to the debug module's tck-side status path.

Parameters:
ADDR_W, 32, Avalon byte-address width; MonAReg width.
TIMEOUT_CYCLES, 255, max consecutive waitrequest-high cycles before abort (1..65535).

Ports:
clk  in  1  system clock, same as debug module sysclk side
reset_n  in  1  asynchronous active-low reset
jdo  in  38  debug data word from sysclk stage
take_action_ocimem_a  in  1  1-cycle pulse: address-load command
take_no_action_ocimem_a  in  1  1-cycle pulse: read-next command
take_action_ocimem_b  in  1  1-cycle pulse: write command
avm_address  out  ADDR_W  bus address, bits[1:0] always 0
avm_read  out  1  read request
avm_write  out  1  write request
avm_writedata  out  32  write data (= MonDReg)
avm_byteenable  out  4  constant 4'hF
avm_readdata  in  32  read data
avm_waitrequest  in  1  slave stall
MonDReg  out  32  monitor data register
monitor_ready  out  1  last command finished, engine idle
monitor_error  out  1  last command aborted by timeout

Behaviour:
- Reset (async, any state): FSM=IDLE, MonAReg=0, MonDReg=0, avm_read=avm_write=0, timeout counter=0, monitor_ready=1, monitor_error=0.
- FSM states: IDLE, RD, WR.
- Commands are accepted only in IDLE. Pulses arriving in RD/WR are dropped with no side effect.
- Same-cycle priority: take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a.
- Address load (ocimem_a):
  - MonAReg <= {jdo[ADDR_W-1:2],2'b00}.
  - If jdo[35]=1: go to RD.
  - If jdo[35]=0: stay IDLE; monitor_ready and monitor_error unchanged.
- Write (ocimem_b): MonDReg <= jdo[31:0]; go to WR.
- Read-next (no_action_a): go to RD.
- Any accepted command that enters RD/WR clears monitor_ready and monitor_error on the same edge.
- Bus request timing: accept at edge N; avm_read/avm_write high from cycle N+1, avm_address=MonAReg. The request is held stable until the first cycle with avm_waitrequest=0.
- Read completion (no-waitrequest cycle):
  - MonDReg <= avm_readdata.
  - Increment MonAReg by 4, but only for read-next. An address-load read does not increment.
  - Back to IDLE; monitor_ready=1. Latency with waitrequest tied low = 2 edges from command to ready.
- Write completion: MonAReg += 4; IDLE; monitor_ready=1.
- Increment wraps modulo 2^ADDR_W (max word address + 4 -> 0).
- Timeout:
  - The counter resets on entering RD/WR and increments each cycle with waitrequest=1.
  - When it reaches TIMEOUT_CYCLES while waitrequest is still 1: drop the request the next cycle, go to IDLE, set monitor_ready=1 and monitor_error=1.
  - MonDReg and MonAReg are unchanged on timeout.
- avm_read and avm_write are never high together. Both are low in IDLE.
- Reset asserted mid-transaction drops the request immediately (async) and restores the reset values.

Test Plan:
- Reset, then ocimem_a with jdo[31:0]=0x0000_1003, jdo[35]=1, waitrequest=0, readdata=0xCAFEF00D -> avm_read 1 cycle at addr 0x1000; MonDReg=0xCAFEF00D; MonAReg stays 0x1000; monitor_ready 0->1 two edges after command.
- ocimem_b jdo=0x12345678, then 3 waitrequest cycles -> avm_write held 4 cycles with addr 0x1000 and data 0x12345678; MonAReg=0x1004; monitor_ready=1, monitor_error=0.
- ADDR_W=32, MonAReg=0xFFFF_FFFC, then read-next -> read at 0xFFFFFFFC; MonAReg wraps to 0x0000_0000.
- TIMEOUT_CYCLES=4, waitrequest stuck high on a write -> request dropped after 4 stall cycles; monitor_error=1, monitor_ready=1; MonAReg unchanged. Next read-next with waitrequest=0 clears monitor_error.
- ocimem_a and ocimem_b pulsed in the same cycle -> only the address load executes. A read-next pulse during RD -> ignored, no extra bus cycle.
- reset_n dropped while avm_read is stalled -> avm_read=0 immediately; after release all outputs are at reset values.
